// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
`timescale 1ns/1ps
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input; RESET_VALUE sets the
// level both flops take under reset, so the output does not glitch out of reset.
`timescale 1ns/1ps
module uart_sync #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic synced
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta   <= RESET_VALUE;
            synced <= RESET_VALUE;
        end else begin
            meta   <= raw;
            synced <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of a synchronized line, one-cycle strobes
// for each good byte and for each low stop bit.
`timescale 1ns/1ps
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 uart_rxd,
    output logic [DATA_BITS-1:0] uart_rx_output,
    output logic                 uart_rx_valid,
    output logic                 uart_rx_frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_IDX  = 3'(DATA_BITS - 1);

    logic                 rxd_s;
    uart_state_t          state;
    logic [CW-1:0]        cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 line_armed;

    uart_sync #(
        .RESET_VALUE(IDLE_LEVEL)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .raw   (uart_rxd),
        .synced(rxd_s)
    );

    // line_armed blocks a held-low line (break) from being re-read as a new start bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state             <= IDLE;
            cnt               <= '0;
            bit_idx           <= '0;
            line_armed        <= 1'b0;
            uart_rx_output    <= '0;
            uart_rx_valid     <= 1'b0;
            uart_rx_frame_err <= 1'b0;
        end else begin
            uart_rx_valid     <= 1'b0;
            uart_rx_frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (rxd_s == IDLE_LEVEL) begin
                        line_armed <= 1'b1;
                    end else if (line_armed) begin
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= (rxd_s == IDLE_LEVEL) ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == LAST_IDX) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    // Return to IDLE at mid-stop-bit so back-to-back frames are caught.
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (rxd_s == IDLE_LEVEL) begin
                            uart_rx_output <= shreg;
                            uart_rx_valid  <= 1'b1;
                        end else begin
                            uart_rx_frame_err <= 1'b1;
                            line_armed        <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == DATA && cnt == BIT_LAST) begin
            shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: a frame-level model predicts each strobe's kind,
// cycle and byte from the frames the bench puts on the line.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CPB = 20;
    // fall edge -> 2 sync cycles -> half bit -> 9 bits -> 1 cycle register
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       uart_rxd = 1'b1;
    logic [7:0] uart_rx_output;
    logic       uart_rx_valid;
    logic       uart_rx_frame_err;

    uart_rx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .uart_rxd         (uart_rxd),
        .uart_rx_output   (uart_rx_output),
        .uart_rx_valid    (uart_rx_valid),
        .uart_rx_frame_err(uart_rx_frame_err)
    );

    always #1 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         ferr;
        logic [7:0] data;
        int         at;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        mon_e;
    logic [7:0] exp_out = 8'h00;
    bit         armed_m = 1'b0;
    int         valid_cycles[$];
    int         n_ferr = 0;
    int         tests_run = 0;
    int         tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (uart_rx_valid || uart_rx_frame_err) begin
            check("both_strobes", 32'(uart_rx_valid & uart_rx_frame_err), 32'd0);
            if (uart_rx_frame_err) n_ferr++;
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 32'({uart_rx_valid, uart_rx_frame_err}), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("strobe_kind", 32'(uart_rx_frame_err), 32'(mon_e.ferr));
                check("strobe_cycle", cyc, mon_e.at);
                if (!mon_e.ferr) exp_out = mon_e.data;
                check("strobe_data", 32'(uart_rx_output), 32'(exp_out));
                if (uart_rx_valid) valid_cycles.push_back(cyc);
            end
        end
    end

    task automatic hold(input logic lvl, input int n);
        uart_rxd = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        if (n > 0) armed_m = 1'b1;
        hold(1'b1, n);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop);
        ev_t e;
        e.ferr = !stop;
        e.data = b;
        e.at   = cyc + LAT;
        if (armed_m) exp_q.push_back(e);
        if (!stop) armed_m = 1'b0;
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
        hold(stop, CPB);
    endtask

    task automatic glitch(input int len);
        hold(1'b0, len);
        idle(CPB);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", exp_q.size(), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d required below 200000", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rb;
        int         r;
        bit         st;
        int         f0;

        // reset held with line idle
        reset = 1'b0;
        uart_rxd = 1'b1;
        repeat (100) @(negedge clk);
        check("rst_out", 32'(uart_rx_output), 32'h00);
        check("rst_valid", 32'(uart_rx_valid), 32'd0);
        check("rst_ferr", 32'(uart_rx_frame_err), 32'd0);
        reset = 1'b1;
        idle(20);

        // single byte
        valid_cycles.delete();
        send_frame(8'h34, 1'b1);
        idle(20);
        drain(500);
        check("single_count", valid_cycles.size(), 32'd1);
        check("single_out", 32'(uart_rx_output), 32'h34);
        check("single_ferr_count", n_ferr, 32'd0);

        // back-to-back
        valid_cycles.delete();
        send_frame(8'h55, 1'b1);
        send_frame(8'hA5, 1'b1);
        idle(20);
        drain(500);
        check("b2b_count", valid_cycles.size(), 32'd2);
        if (valid_cycles.size() == 2) check("b2b_gap", valid_cycles[1] - valid_cycles[0], 32'd200);
        check("b2b_out", 32'(uart_rx_output), 32'hA5);

        // glitch rejection then good frame
        valid_cycles.delete();
        glitch(5);
        send_frame(8'h34, 1'b1);
        idle(20);
        drain(500);
        check("glitch_count", valid_cycles.size(), 32'd1);
        check("glitch_out", 32'(uart_rx_output), 32'h34);

        // framing error followed by break
        send_frame(8'hA5, 1'b1);
        idle(5);
        f0 = n_ferr;
        valid_cycles.delete();
        send_frame(8'h34, 1'b0);
        hold(1'b0, 1000);
        check("ferr_count", n_ferr - f0, 32'd1);
        check("ferr_valid_count", valid_cycles.size(), 32'd0);
        check("ferr_keep_out", 32'(uart_rx_output), 32'hA5);
        idle(20);
        send_frame(8'h55, 1'b1);
        idle(20);
        drain(500);
        check("post_break_out", 32'(uart_rx_output), 32'h55);

        // reset during data bit 3
        valid_cycles.delete();
        fork
            send_frame(8'h34, 1'b1);
            begin
                repeat (4 * CPB + CPB / 2) @(negedge clk);
                reset = 1'b0;
                exp_q.delete();
                exp_out = 8'h00;
                armed_m = 1'b0;
            end
        join
        check("midrst_out", 32'(uart_rx_output), 32'h00);
        reset = 1'b1;
        idle(20);
        check("midrst_count", valid_cycles.size(), 32'd0);
        check("midrst_out_after", 32'(uart_rx_output), 32'h00);

        // loopback-style pair
        send_frame(8'h34, 1'b1);
        send_frame(8'h55, 1'b1);
        idle(20);
        drain(500);
        check("loop_count", valid_cycles.size(), 32'd2);
        check("loop_out", 32'(uart_rx_output), 32'h55);

        // randomized traffic
        for (int k = 0; k < 30; k++) begin
            r  = int'($urandom_range(0, 9));
            rb = 8'($urandom);
            st = (r != 1);
            if (r == 0) glitch(int'($urandom_range(1, CPB / 2 - 2)));
            send_frame(rb, st);
            if (st) idle(int'($urandom_range(0, 3)));
            else    idle(int'($urandom_range(1, 8)));
        end
        idle(30);
        drain(500);
        check("rand_final_out", 32'(uart_rx_output), 32'(exp_out));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
